// File: rtl/se_blend_pipe.sv
// Three-stage special-effects colour pipe: passthrough, alpha blend, brighten and darken, applied per channel.
// Optional build macro SE_ROUND_EN switches every >>4 to round-half-up; when it is undefined the shifts truncate.
module se_blend_pipe #(
    parameter int CH_W   = 5,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode,
    input  logic [NUM_CH*CH_W-1:0]   first,
    input  logic [NUM_CH*CH_W-1:0]   second,
    input  logic [4:0]               eva,
    input  logic [4:0]               evb,
    input  logic [4:0]               evy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   color,
    output logic [CNT_W-1:0]         px_count
);

    localparam int PW  = NUM_CH * CH_W;
    localparam int PRW = CH_W + 5;
    localparam int SW  = CH_W + 6;
    localparam logic [CH_W-1:0] MAXC = '1;
`ifdef SE_ROUND_EN
    localparam int RND = 8;
`else
    localparam int RND = 0;
`endif
    localparam logic [SW-1:0]  RND_S = SW'(RND);
    localparam logic [PRW:0]   RND_P = (PRW + 1)'(RND);

    localparam logic [1:0] M_BLEND  = 2'b01;
    localparam logic [1:0] M_BRIGHT = 2'b10;
    localparam logic [1:0] M_DARK   = 2'b11;

    function automatic logic [4:0] clamp16(input logic [4:0] c);
        return (c > 5'd16) ? 5'd16 : c;
    endfunction

    logic en;

    logic                 s1_valid_reg;
    logic [1:0]           s1_mode_reg;
    logic [PW-1:0]        s1_a_reg;
    logic [PW-1:0]        s1_b_reg;
    logic [4:0]           s1_eva_reg;
    logic [4:0]           s1_evb_reg;
    logic [4:0]           s1_evy_reg;

    logic                 s2_valid_reg;
    logic [1:0]           s2_mode_reg;
    logic [PW-1:0]        s2_a_reg;
    logic [NUM_CH-1:0][PRW-1:0] s2_pa_reg, s2_pb_reg, s2_pu_reg, s2_pd_reg;
    logic [NUM_CH-1:0][PRW-1:0] pa_next, pb_next, pu_next, pd_next;

    logic                 out_valid_reg;
    logic [PW-1:0]        color_reg;
    logic [PW-1:0]        color_next;
    logic [CNT_W-1:0]     px_count_reg;

    // A stalled output freezes the whole pipe; bubbles are kept in place.
    assign en        = !out_valid_reg || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_reg;
    assign color     = color_reg;
    assign px_count  = px_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_mul
            logic [CH_W-1:0] a_ch;
            logic [CH_W-1:0] b_ch;
            assign a_ch = s1_a_reg[gi*CH_W +: CH_W];
            assign b_ch = s1_b_reg[gi*CH_W +: CH_W];
            assign pa_next[gi] = PRW'(a_ch) * PRW'(s1_eva_reg);
            assign pb_next[gi] = PRW'(b_ch) * PRW'(s1_evb_reg);
            assign pu_next[gi] = PRW'(MAXC - a_ch) * PRW'(s1_evy_reg);
            assign pd_next[gi] = PRW'(a_ch) * PRW'(s1_evy_reg);
        end

        for (gi = 0; gi < NUM_CH; gi++) begin : g_comb
            logic [CH_W-1:0] a_ch;
            logic [CH_W-1:0] res;
            logic [SW-1:0]   sum_w;
            logic [CH_W+1:0] bq;
            logic [PRW:0]    pu_w;
            logic [PRW:0]    pd_w;
            logic [CH_W-1:0] up;
            logic [CH_W-1:0] dn;

            assign a_ch  = s2_a_reg[gi*CH_W +: CH_W];
            assign sum_w = SW'(s2_pa_reg[gi]) + SW'(s2_pb_reg[gi]) + RND_S;
            assign bq    = (CH_W + 2)'(sum_w >> 4);
            // With EVY<=16 these steps are bounded by MAXC-A and A, so no clamp is needed.
            assign pu_w  = {1'b0, s2_pu_reg[gi]} + RND_P;
            assign pd_w  = {1'b0, s2_pd_reg[gi]} + RND_P;
            assign up    = CH_W'(pu_w >> 4);
            assign dn    = CH_W'(pd_w >> 4);

            always_comb begin
                res = a_ch;
                case (s2_mode_reg)
                    M_BLEND:  res = (bq > (CH_W + 2)'(MAXC)) ? MAXC : bq[CH_W-1:0];
                    M_BRIGHT: res = a_ch + up;
                    M_DARK:   res = a_ch - dn;
                    default:  res = a_ch;
                endcase
            end

            assign color_next[gi*CH_W +: CH_W] = res;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_mode_reg   <= '0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_eva_reg    <= '0;
            s1_evb_reg    <= '0;
            s1_evy_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_mode_reg   <= '0;
            s2_a_reg      <= '0;
            s2_pa_reg     <= '0;
            s2_pb_reg     <= '0;
            s2_pu_reg     <= '0;
            s2_pd_reg     <= '0;
            out_valid_reg <= 1'b0;
            color_reg     <= '0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s1_mode_reg   <= mode;
            s1_a_reg      <= first;
            s1_b_reg      <= second;
            s1_eva_reg    <= clamp16(eva);
            s1_evb_reg    <= clamp16(evb);
            s1_evy_reg    <= clamp16(evy);
            s2_valid_reg  <= s1_valid_reg;
            s2_mode_reg   <= s1_mode_reg;
            s2_a_reg      <= s1_a_reg;
            s2_pa_reg     <= pa_next;
            s2_pb_reg     <= pb_next;
            s2_pu_reg     <= pu_next;
            s2_pd_reg     <= pd_next;
            out_valid_reg <= s2_valid_reg;
            color_reg     <= color_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            px_count_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            px_count_reg <= px_count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_se_blend_pipe.sv
// Randomised and directed bench for se_blend_pipe, scored against a per-channel arithmetic model.
// A queue of expected pixels is kept in acceptance order; every output cycle is compared against its head.
module tb_se_blend_pipe;

    localparam int CH_W   = 5;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int PW     = NUM_CH * CH_W;
`ifdef SE_ROUND_EN
    localparam int RND = 8;
    localparam logic [4:0] E_BRIGHT = 5'd21;
    localparam logic [4:0] E_DARK   = 5'd15;
`else
    localparam int RND = 0;
    localparam logic [4:0] E_BRIGHT = 5'd20;
    localparam logic [4:0] E_DARK   = 5'd16;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [PW-1:0]    first;
    logic [PW-1:0]    second;
    logic [4:0]       eva;
    logic [4:0]       evb;
    logic [4:0]       evy;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    color;
    logic [CNT_W-1:0] px_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int delivered    = 0;
    int accepted     = 0;
    bit verbose      = 1'b1;
    logic [PW-1:0] exp_q[$];

    se_blend_pipe #(.CH_W(CH_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .first     (first),
        .second    (second),
        .eva       (eva),
        .evb       (evb),
        .evy       (evy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .color     (color),
        .px_count  (px_count)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [1:0] m, input logic [PW-1:0] a,
                                            input logic [PW-1:0] b, input logic [4:0] ea,
                                            input logic [4:0] eb, input logic [4:0] ey);
        int ca, cb, cy, av, bv, r;
        logic [PW-1:0] res;
        ca  = (int'(ea) > 16) ? 16 : int'(ea);
        cb  = (int'(eb) > 16) ? 16 : int'(eb);
        cy  = (int'(ey) > 16) ? 16 : int'(ey);
        res = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            av = int'(a[ch*CH_W +: CH_W]);
            bv = int'(b[ch*CH_W +: CH_W]);
            case (m)
                2'b00: r = av;
                2'b01: begin
                    r = (av * ca + bv * cb + RND) / 16;
                    if (r > 31) r = 31;
                end
                2'b10: r = av + ((31 - av) * cy + RND) / 16;
                default: r = av - (av * cy + RND) / 16;
            endcase
            res[ch*CH_W +: CH_W] = r[CH_W-1:0];
        end
        return res;
    endfunction

    // One clock of traffic: called at a falling edge with inputs already driven.
    task automatic step();
        #1;
        check("px_count", {16'd0, px_count}, 32'(delivered % 65536));
        if (out_valid) begin
            check("out_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                check("color", {17'd0, color}, {17'd0, exp_q[0]});
                if (out_ready) begin
                    if (verbose) $display("[TB] px %0d color=%h", delivered, color);
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
            if (!out_ready) check("stall_rdy", {31'd0, in_ready}, 32'd0);
        end else begin
            check("idle_rdy", {31'd0, in_ready}, 32'd1);
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(mode, first, second, eva, evb, evy));
            accepted++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        delivered = 0;
        accepted  = 0;
    endtask

    task automatic rand_pixel();
        mode   = 2'($urandom_range(0, 3));
        first  = PW'($urandom);
        second = PW'($urandom);
        eva    = 5'($urandom_range(0, 31));
        evb    = 5'($urandom_range(0, 31));
        evy    = 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [1:0] m, input logic [4:0] av,
                            input logic [4:0] bv, input logic [4:0] ea, input logic [4:0] eb,
                            input logic [4:0] ey, input logic [4:0] expv);
        int lat;
        mode      = m;
        first     = {3{av}};
        second    = {3{bv}};
        eva       = ea;
        evb       = eb;
        evy       = ey;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 10) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check(tag, {17'd0, color}, {17'd0, {3{expv}}});
        step();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
        first = '0; second = '0; eva = '0; evb = '0; evy = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_color", {17'd0, color}, 32'd0);
        check("rst_count", {16'd0, px_count}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        directed("blend_20_10",  2'b01, 5'd20, 5'd10, 5'd8,  5'd8,  5'd0,  5'd15);
        directed("blend_sat",    2'b01, 5'd31, 5'd31, 5'd20, 5'd20, 5'd0,  5'd31);
        directed("bright_10",    2'b10, 5'd10, 5'd0,  5'd0,  5'd0,  5'd8,  E_BRIGHT);
        directed("bright_0_16",  2'b10, 5'd0,  5'd0,  5'd0,  5'd0,  5'd16, 5'd31);
        directed("pass_7",       2'b00, 5'd7,  5'd3,  5'd9,  5'd9,  5'd9,  5'd7);
        directed("dark_31",      2'b11, 5'd31, 5'd0,  5'd0,  5'd0,  5'd8,  E_DARK);

        // Six pixels through a five-cycle output stall.
        do_reset();
        for (int c = 0; c < 40 && delivered < 6; c++) begin
            in_valid  = (accepted < 6);
            rand_pixel();
            out_ready = !(c >= 4 && c <= 8);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_count", {16'd0, px_count}, 32'd6);
        check("stall_queue", 32'(exp_q.size()), 32'd0);

        // Reset with pixels in flight and one already delivered.
        do_reset();
        mode = 2'b00; first = 15'h5A5A; second = '0; in_valid = 1'b1;
        repeat (4) step();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_color", {17'd0, color}, 32'd0);
        check("midrst_count", {16'd0, px_count}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        delivered = 0;
        accepted  = 0;
        repeat (6) step();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_pixel();
            step();
        end
        drain();

        // Counter wrap after 65536 deliveries.
        do_reset();
        verbose   = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (accepted < 65536) begin
            first = PW'($urandom);
            step();
        end
        drain();
        check("wrap_delivered", 32'(delivered), 32'd65536);
        check("wrap_count", {16'd0, px_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
